// File: rtl/gol_gen_scheduler.sv
// gol_gen_scheduler: starts Game of Life generations (free-running period or single step)
//   and toggles single cells of the read field via read-modify-write on the RAM edit port.
// Latency: step sampled -> o_go two cycles later; edit accepted in IDLE -> o_edit_ack two cycles later.
// Backpressure: step/period requests are held in saturating pending flags until START;
//   an edit request is held by the requester and waits until the block is IDLE.
//
// Optional edit path: define GOL_SCHED_EDIT_EN to build EDIT_RD/EDIT_WR; otherwise every edit
// output is tied to 0 and i_edit_*/i_mem_rdata are ignored.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_run, i_period       free-running enable and period in cycles (0 behaves as 1)
//   i_step                one-cycle pulse requesting a single generation
//   i_is_simulating       iterator busy flag
//   o_go                  one-cycle start pulse to the iterator
//   i_edit_req/x/y        cell toggle request (level, held until o_edit_ack)
//   o_edit_ack            one-cycle acknowledge; the toggle has been written
//   o_mem_*/i_mem_rdata   field RAM edit port (sel, address, read/write strobes, data)
//   o_busy, o_gen_cnt     FSM not idle; completed generation count (wraps)
module gol_gen_scheduler #(
    parameter int FIELD_W   = 32,
    parameter int FIELD_H   = 32,
    parameter int PERIOD_W  = 24,
    parameter int GEN_CNT_W = 16,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    input  logic                  i_step,
    input  logic [PERIOD_W-1:0]   i_period,
    input  logic                  i_is_simulating,
    output logic                  o_go,
    input  logic                  i_edit_req,
    input  logic [X_ADR_SIZE-1:0] i_edit_x,
    input  logic [Y_ADR_SIZE-1:0] i_edit_y,
    output logic                  o_edit_ack,
    output logic                  o_mem_sel,
    output logic [X_ADR_SIZE-1:0] o_mem_x,
    output logic [Y_ADR_SIZE-1:0] o_mem_y,
    output logic                  o_mem_re,
    input  logic                  i_mem_rdata,
    output logic                  o_mem_we,
    output logic                  o_mem_wdata,
    output logic                  o_busy,
    output logic [GEN_CNT_W-1:0]  o_gen_cnt
);

    typedef enum logic [2:0] {IDLE, START, SIM, EDIT_RD, EDIT_WR} state_t;

    state_t                state, state_nxt;
    logic                  step_pending, gen_pending;
    logic [PERIOD_W-1:0]   period_cnt, reload;
    logic                  tick;
    logic                  edit_take;
    logic                  consume_step, consume_gen;
    logic [GEN_CNT_W-1:0]  gen_cnt;

    // The counter runs up from 0 to max(period,1)-1; 0 is its reload position, which keeps the
    // reset value constant. ">=" tolerates the period shrinking mid-count.
    assign reload = (i_period == '0) ? '0 : i_period - PERIOD_W'(1);
    assign tick   = i_run && (period_cnt >= reload);

`ifdef GOL_SCHED_EDIT_EN
    assign edit_take = i_edit_req;
`else
    assign edit_take = 1'b0;
`endif

    // Step wins when both requests are pending; the other one stays for the next START.
    assign consume_step = (state == START) && step_pending;
    assign consume_gen  = (state == START) && !step_pending;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (edit_take)
                    state_nxt = EDIT_RD;
                else if ((gen_pending || step_pending) && !i_is_simulating)
                    state_nxt = START;
            end
            START:   state_nxt = SIM;
            SIM:     if (!i_is_simulating) state_nxt = IDLE;
`ifdef GOL_SCHED_EDIT_EN
            EDIT_RD: state_nxt = EDIT_WR;
            EDIT_WR: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            step_pending <= 1'b0;
            gen_pending  <= 1'b0;
            period_cnt   <= '0;
            gen_cnt      <= '0;
        end else begin
            state <= state_nxt;

            // A request arriving on the consuming edge is kept rather than lost.
            if (i_step)
                step_pending <= 1'b1;
            else if (consume_step)
                step_pending <= 1'b0;

            if (!i_run) begin
                period_cnt  <= '0;
                gen_pending <= 1'b0;
            end else if (tick) begin
                period_cnt  <= '0;
                gen_pending <= 1'b1;
            end else begin
                period_cnt <= period_cnt + PERIOD_W'(1);
                if (consume_gen)
                    gen_pending <= 1'b0;
            end

            if ((state == SIM) && !i_is_simulating)
                gen_cnt <= gen_cnt + GEN_CNT_W'(1);
        end
    end

    assign o_go      = (state == START);
    assign o_busy    = (state != IDLE);
    assign o_gen_cnt = gen_cnt;

`ifdef GOL_SCHED_EDIT_EN
    logic [X_ADR_SIZE-1:0] edit_x_q;
    logic [Y_ADR_SIZE-1:0] edit_y_q;

    // Coordinates are captured on acceptance so the RAM address is a register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edit_x_q <= '0;
            edit_y_q <= '0;
        end else if ((state == IDLE) && edit_take) begin
            edit_x_q <= i_edit_x;
            edit_y_q <= i_edit_y;
        end
    end

    assign o_mem_sel   = (state == EDIT_RD) || (state == EDIT_WR);
    assign o_mem_re    = (state == EDIT_RD);
    assign o_mem_we    = (state == EDIT_WR);
    assign o_edit_ack  = (state == EDIT_WR);
    // RAM data arrives from the read issued in EDIT_RD; gated so it is 0 outside the write.
    assign o_mem_wdata = (state == EDIT_WR) && !i_mem_rdata;
    assign o_mem_x     = o_mem_sel ? edit_x_q : '0;
    assign o_mem_y     = o_mem_sel ? edit_y_q : '0;
`else
    logic unused_edit;
    assign unused_edit = ^{i_edit_req, i_edit_x, i_edit_y, i_mem_rdata};

    assign o_mem_sel   = 1'b0;
    assign o_mem_re    = 1'b0;
    assign o_mem_we    = 1'b0;
    assign o_edit_ack  = 1'b0;
    assign o_mem_wdata = 1'b0;
    assign o_mem_x     = '0;
    assign o_mem_y     = '0;
`endif

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Bench for gol_gen_scheduler: reactive iterator and field RAM, a cycle model of the scheduling
// rules compared every cycle, and directed scenarios with hand-computed event timings.
module tb_gol_gen_scheduler;
    localparam int FW = 32, FH = 32, PW = 24, GW = 16, XW = 5, YW = 5;
`ifdef GOL_SCHED_EDIT_EN
    localparam bit EDIT_EN = 1'b1;
`else
    localparam bit EDIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_run = 0, i_step = 0, i_edit_req = 0, i_mem_rdata = 0;
    logic [PW-1:0] i_period = '0;
    logic [XW-1:0] i_edit_x = '0;
    logic [YW-1:0] i_edit_y = '0;
    logic          iter_busy = 0, misuse_busy = 0;
    logic          i_is_simulating;
    logic          o_go, o_edit_ack, o_mem_sel, o_mem_re, o_mem_we, o_mem_wdata, o_busy;
    logic [XW-1:0] o_mem_x;
    logic [YW-1:0] o_mem_y;
    logic [GW-1:0] o_gen_cnt;

    assign i_is_simulating = iter_busy | misuse_busy;

    gol_gen_scheduler #(.FIELD_W(FW), .FIELD_H(FH), .PERIOD_W(PW), .GEN_CNT_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_step(i_step), .i_period(i_period),
        .i_is_simulating(i_is_simulating), .o_go(o_go), .i_edit_req(i_edit_req),
        .i_edit_x(i_edit_x), .i_edit_y(i_edit_y), .o_edit_ack(o_edit_ack),
        .o_mem_sel(o_mem_sel), .o_mem_x(o_mem_x), .o_mem_y(o_mem_y), .o_mem_re(o_mem_re),
        .i_mem_rdata(i_mem_rdata), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .o_busy(o_busy), .o_gen_cnt(o_gen_cnt)
    );

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Iterator: raises busy on the edge ending START and stays busy for iter_len cycles.
    int iter_len = 16;
    initial forever begin
        @(negedge clk);
        if (o_go) begin
            @(posedge clk); #1 iter_busy = 1'b1;
            repeat (iter_len) @(posedge clk);
            #1 iter_busy = 1'b0;
        end
    end

    // Field RAM: synchronous read, data valid the cycle after the strobe.
    logic [FW-1:0] ram [FH];
    initial begin
        logic cre, cwe, cwd;
        logic [XW-1:0] cx;
        logic [YW-1:0] cy;
        for (int y = 0; y < FH; y++) ram[y] = '0;
        forever begin
            @(negedge clk);
            cre = o_mem_re; cwe = o_mem_we; cwd = o_mem_wdata; cx = o_mem_x; cy = o_mem_y;
            @(posedge clk); #1;
            if (cre) i_mem_rdata = ram[cy][cx];
            if (cwe) ram[cy][cx] = cwd;
        end
    end

    // Behavioural model: activity kind + start cycle, pending requests, run age.
    int            m_mode;          // 0 idle, 1 generation, 2 edit
    int            m_t0;            // cycle of o_go or of the edit read
    bit            m_sp, m_gp;
    int            m_age;           // consecutive run cycles
    logic [GW-1:0] m_gc;
    int            mx, my;
    logic [FW-1:0] mram [FH];
    logic [GW-1:0] prev_gc;

    int go_q[$], cnt_q[$], ack_q[$], re_q[$], wd_q[$];
    int rx, ry;

    task automatic model_reset();
        m_mode = 0; m_t0 = 0; m_sp = 0; m_gp = 0; m_age = 0; m_gc = '0;
    endtask

    task automatic model_step(input int k);
        bit sp, gp;
        int pe;
        sp = m_sp; gp = m_gp;
        case (m_mode)
            0: begin
                if (EDIT_EN && i_edit_req) begin
                    m_mode = 2; m_t0 = k + 1; mx = int'(i_edit_x); my = int'(i_edit_y);
                end else if ((sp || gp) && !i_is_simulating) begin
                    m_mode = 1; m_t0 = k + 1;
                end
            end
            1: begin
                if (k == m_t0) begin
                    if (sp) m_sp = 0; else m_gp = 0;
                end else if (!i_is_simulating) begin
                    m_mode = 0; m_gc = m_gc + GW'(1);
                end
            end
            default: begin
                if (k == m_t0 + 1) begin
                    mram[my][mx] = ~mram[my][mx];
                    m_mode = 0;
                end
            end
        endcase
        if (i_step) m_sp = 1;
        pe = (i_period == '0) ? 1 : int'(i_period);
        if (!i_run) begin
            m_age = 0; m_gp = 0;
        end else begin
            m_age++;
            if (m_age % pe == 0) m_gp = 1;
        end
    endtask

    initial begin
        int  k;
        bit  e_go, e_busy, e_sel, e_re, e_we, e_wd;
        for (int y = 0; y < FH; y++) mram[y] = '0;
        model_reset();
        prev_gc = '0;
        forever begin
            @(negedge clk);
            k = cyc;
            if (!rst_n) begin
                model_reset();
                prev_gc = '0;
            end
            e_go   = (m_mode == 1) && (k == m_t0);
            e_busy = (m_mode != 0);
            e_sel  = (m_mode == 2);
            e_re   = e_sel && (k == m_t0);
            e_we   = e_sel && (k == m_t0 + 1);
            e_wd   = e_we && !mram[my][mx];
            chk("go", int'(o_go), int'(e_go));
            chk("busy", int'(o_busy), int'(e_busy));
            chk("gen_cnt", int'(o_gen_cnt), int'(m_gc));
            chk("edit_ack", int'(o_edit_ack), int'(e_we));
            chk("mem_sel", int'(o_mem_sel), int'(e_sel));
            chk("mem_re", int'(o_mem_re), int'(e_re));
            chk("mem_we", int'(o_mem_we), int'(e_we));
            chk("mem_wdata", int'(o_mem_wdata), int'(e_wd));
            if (e_sel) begin
                chk("mem_x", int'(o_mem_x), mx);
                chk("mem_y", int'(o_mem_y), my);
            end
            if (rst_n) begin
                if (o_go) go_q.push_back(k);
                if (o_gen_cnt != prev_gc) cnt_q.push_back(k);
                prev_gc = o_gen_cnt;
                if (o_mem_re) begin re_q.push_back(k); rx = int'(o_mem_x); ry = int'(o_mem_y); end
                if (o_edit_ack) begin ack_q.push_back(k); wd_q.push_back(int'(o_mem_wdata)); end
                model_step(k);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_go"}, int'(o_go), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_gen_cnt"}, int'(o_gen_cnt), 0);
        chk({tag, "_ack"}, int'(o_edit_ack), 0);
        chk({tag, "_sel"}, int'(o_mem_sel), 0);
        chk({tag, "_re"}, int'(o_mem_re), 0);
        chk({tag, "_we"}, int'(o_mem_we), 0);
        chk({tag, "_wdata"}, int'(o_mem_wdata), 0);
        chk({tag, "_xy"}, int'({o_mem_x, o_mem_y}), 0);
    endtask

    task automatic pulse_step(output int s);
        s = cyc; i_step = 1; step_cycles(1); i_step = 0;
    endtask

    // Run free-running for len cycles at period p, then let the last generation drain.
    task automatic run_burst(input int p, input int len, input string tag,
                             input int n_exp, input int first_exp, input int gap_exp);
        int r, g0;
        go_q.delete(); g0 = int'(o_gen_cnt);
        i_period = PW'(p); r = cyc; i_run = 1;
        step_cycles(len);
        i_run = 0;
        step_cycles(30);
        chk({tag, "_count"}, go_q.size(), n_exp);
        if (go_q.size() > 0) chk({tag, "_first"}, go_q[0] - r, first_exp);
        for (int i = 1; i < go_q.size(); i++) chk({tag, "_gap"}, go_q[i] - go_q[i-1], gap_exp);
        chk({tag, "_gencnt"}, int'(o_gen_cnt) - g0, n_exp);
    endtask

    task automatic do_edit(input int x, input int y, output int t);
        int n0;
        n0 = ack_q.size();
        i_edit_x = XW'(x); i_edit_y = YW'(y);
        t = cyc; i_edit_req = 1;
        for (int i = 0; i < 60 && ack_q.size() == n0; i++) step_cycles(1);
        i_edit_req = 0;
        chk("edit_ack_seen", ack_q.size(), n0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, t, m, g;
        step_cycles(3);
        chk_reset_vals("reset");
        rst_n = 1;

        // Idle with run off: nothing starts.
        go_q.delete();
        step_cycles(100);
        chk("idle_go_count", go_q.size(), 0);
        chk("idle_gen_cnt", int'(o_gen_cnt), 0);

        // Single step: go two cycles after the pulse, count bumps 18 cycles after go.
        go_q.delete(); cnt_q.delete();
        pulse_step(s);
        step_cycles(25);
        chk("step_go_count", go_q.size(), 1);
        if (go_q.size() > 0) chk("step_latency", go_q[0] - s, 2);
        chk("step_cnt_changes", cnt_q.size(), 1);
        if (go_q.size() > 0 && cnt_q.size() > 0) chk("step_gen_done", cnt_q[0] - go_q[0], 18);
        chk("step_gen_cnt", int'(o_gen_cnt), 1);

        // Period 50: exact spacing. Period 5 and 0: ticks dropped, one go per 19 cycles.
        run_burst(50, 505, "run50", 10, 51, 50);
        chk("run50_total", int'(o_gen_cnt), 11);
        run_burst(5, 150, "run5", 8, 6, 19);
        run_burst(0, 45, "run0", 3, 2, 19);

        // Iterator busy while IDLE: a pending step waits for it to drop.
        go_q.delete();
        misuse_busy = 1;
        pulse_step(s);
        step_cycles(10);
        chk("misuse_hold", go_q.size(), 0);
        m = cyc; misuse_busy = 0;
        step_cycles(25);
        chk("misuse_go_count", go_q.size(), 1);
        if (go_q.size() > 0) chk("misuse_release", go_q[0] - m, 1);

`ifdef GOL_SCHED_EDIT_EN
        do_edit(3, 7, t);
        if (re_q.size() > 0) chk("edit1_re_lat", re_q[$] - t, 1);
        if (ack_q.size() > 0) chk("edit1_ack_lat", ack_q[$] - t, 2);
        chk("edit1_x", rx, 3);
        chk("edit1_y", ry, 7);
        if (wd_q.size() > 0) chk("edit1_wdata", wd_q[$], 1);
        chk("edit1_ram", int'(ram[7][3]), 1);
        step_cycles(2);
        do_edit(3, 7, t);
        if (wd_q.size() > 0) chk("edit2_wdata", wd_q[$], 0);
        chk("edit2_ram", int'(ram[7][3]), 0);
        step_cycles(2);
        // Edit raised mid-generation is served right after SIM ends.
        go_q.delete();
        pulse_step(s);
        step_cycles(4);
        do_edit(3, 7, t);
        if (go_q.size() > 0 && ack_q.size() > 0) chk("edit_sim_ack", ack_q[$] - go_q[0], 20);
        if (wd_q.size() > 0) chk("edit_sim_wdata", wd_q[$], 1);
        step_cycles(5);
`else
        begin
            int n0, r0;
            n0 = ack_q.size(); r0 = re_q.size();
            i_edit_x = 5'd3; i_edit_y = 5'd7; i_edit_req = 1;
            step_cycles(20);
            i_edit_req = 0;
            chk("noedit_ack", ack_q.size(), n0);
            chk("noedit_re", re_q.size(), r0);
        end
`endif

        // Reset during SIM: immediate return to reset values, then normal operation.
        go_q.delete();
        pulse_step(s);
        step_cycles(6);
        rst_n = 0;
        #1;
        chk_reset_vals("midrst");
        step_cycles(25);
        rst_n = 1;
        step_cycles(2);
        chk("post_rst_gen_cnt", int'(o_gen_cnt), 0);
        go_q.delete();
        pulse_step(s);
        step_cycles(25);
        chk("post_rst_go_count", go_q.size(), 1);
        if (go_q.size() > 0) chk("post_rst_latency", go_q[0] - s, 2);
        chk("post_rst_gen_one", int'(o_gen_cnt), 1);
        g = int'(o_busy);
        chk("post_rst_idle", g, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
